// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - fetch_state_e : FETCH / HOLD / DROP encodings
//   - NOP_INST      : word loaded into IF/ID on a bubble
//   - DEFAULT_RESET_PC : default program counter after reset
//   - align_word()  : clears the byte-offset bits of an address
package if_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(32'd3);
    endfunction

endpackage

// File: rtl/if_fetch_stage_pc_register.sv
// Program-counter register: async active-high reset to RESET_VAL, load-enable.
//   clk, rst : clock / asynchronous reset
//   load     : capture d on the rising edge
//   d, q     : next / current value
module pc_register
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, next-PC selection and a req/ack
// instruction-memory handshake with one-entry buffering while ID stalls.
//   clk_i, rst_i            : clock, async active-high reset
//   stall_i                 : hold IF/ID and PC this cycle
//   branch_i/_target_i      : taken branch from ID (wins over jump)
//   jump_i/jump_target_i    : jump from ID
//   imem_req_o/addr_o       : fetch request, address stable until ack
//   imem_ack_i/data_i       : fetch response (may arrive with the request)
//   pc_o, inst_o            : to IF/ID, fetched address + 4 and word
//   flush_o                 : IF/ID loads a NOP
//   ifid_hold_o             : IF/ID holds its contents
//   bubble_cnt_o            : cycles in which a NOP was inserted
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            flush_o,
    output logic            ifid_hold_o,
    output logic [XLEN-1:0] bubble_cnt_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic            pc_load;
    logic [XLEN-1:0] buf_inst_q;
    logic [XLEN-1:0] drop_addr_q;
    logic [XLEN-1:0] bubble_cnt_q;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic            deliver;
    logic [XLEN-1:0] word;

    assign redirect = branch_i | jump_i;
    assign target   = align_word(branch_i ? branch_target_i : jump_target_i);
    assign pc_plus4 = pc_q + XLEN'(32'd4);

    pc_register #(.RESET_VAL(RESET_PC)) u_pc (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc_q)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stall freezes redirects, an unacked request on
    // redirect must still be drained before the new address can go out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (stall_i) begin
                    if (imem_ack_i) state_d = HOLD;
                end else if (redirect && !imem_ack_i) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (!stall_i) state_d = FETCH;
            end
            DROP: begin
                if (imem_ack_i) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Output and PC-update logic
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        deliver     = 1'b0;
        word        = NOP_INST;
        case (state_q)
            FETCH: begin
                imem_req_o = 1'b1;
                deliver    = imem_ack_i && !stall_i && !redirect;
                word       = imem_data_i;
            end
            HOLD: begin
                deliver = !stall_i && !redirect;
                word    = buf_inst_q;
            end
            DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drop_addr_q;
            end
            default: ;
        endcase
        flush_o     = !deliver;
        ifid_hold_o = stall_i;
        pc_o        = deliver ? pc_plus4 : '0;
        inst_o      = deliver ? word : NOP_INST;
        pc_load     = !stall_i && (deliver || redirect);
        pc_d        = redirect ? target : pc_plus4;
        // Reset abandons any request immediately, without waiting for ack
        if (rst_i) begin
            imem_req_o  = 1'b0;
            imem_addr_o = RESET_PC;
            pc_o        = '0;
            inst_o      = NOP_INST;
            flush_o     = 1'b1;
            ifid_hold_o = 1'b0;
            pc_load     = 1'b0;
        end
    end

    // Fetch buffer, stale-request address and bubble counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_inst_q   <= NOP_INST;
            drop_addr_q  <= RESET_PC;
            bubble_cnt_q <= '0;
        end else begin
            if (state_q == FETCH && stall_i && imem_ack_i) begin
                buf_inst_q <= imem_data_i;
            end
            if (state_q == FETCH && !stall_i && redirect && !imem_ack_i) begin
                drop_addr_q <= pc_q;
            end
            if (flush_o && !ifid_hold_o) begin
                bubble_cnt_q <= bubble_cnt_q + XLEN'(32'd1);
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;

endmodule
